// File: rtl/fir_out_buffer_if.sv
// Handshake bundle between the FIR output stage, its sample source and the draining consumer.
// The producer/consumer side uses the master modport; fir_out_buffer uses the slave modport.
interface fir_out_buffer_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                 In_Valid;
    logic signed [18:0]   Y_In;
    logic                 Flush;
    logic                 Out_Valid;
    logic                 Out_Ready;
    logic signed [14:0]   Out_Data;
    logic [CW-1:0]        Count;
    logic                 Sat_Flag;
    logic                 Overflow;

    modport master (
        output In_Valid, Y_In, Flush, Out_Ready,
        input  Out_Valid, Out_Data, Count, Sat_Flag, Overflow
    );

    modport slave (
        input  In_Valid, Y_In, Flush, Out_Ready,
        output Out_Valid, Out_Data, Count, Sat_Flag, Overflow
    );
endinterface

// File: rtl/fir_out_buffer.sv
// FIR sink stage: drops the start-up transient, saturates 19-bit samples to 15 bits
// and buffers them in a show-ahead FIFO drained with a valid/ready handshake.
module fir_out_buffer #(
    parameter int DEPTH = 8,
    parameter int SKIP  = 33
) (
    input  logic             Clk,
    input  logic             Reset,
    fir_out_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (SKIP < 2) ? 1 : $clog2(SKIP + 1);
    localparam logic [SW-1:0] SKIP_LAST = (SKIP > 0) ? SW'(SKIP - 1) : '0;

    typedef enum logic {FILL, RUN} state_t;
    // With no transient to discard the block starts straight in RUN.
    localparam state_t START_STATE = (SKIP == 0) ? RUN : FILL;

    state_t          state_reg, state_next;
    logic [SW-1:0]   skip_reg, skip_next;
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            sat_reg, sat_next;
    logic            ovf_reg, ovf_next;

    logic signed [14:0] mem [DEPTH];
    logic signed [14:0] sat_data;
    logic               clip;
    logic               full, in_run, pop, push;

    always_comb begin
        sat_data = bus.Y_In[14:0];
        clip     = 1'b0;
        if (bus.Y_In > 19'sd16383) begin
            sat_data = 15'sh3FFF;
            clip     = 1'b1;
        end else if (bus.Y_In < -19'sd16384) begin
            sat_data = 15'sh4000;
            clip     = 1'b1;
        end
    end

    assign full   = (count_reg == CW'(DEPTH));
    assign in_run = (state_reg == RUN);
    assign pop    = (count_reg != '0) && bus.Out_Ready && !bus.Flush;
    assign push   = in_run && bus.In_Valid && (!full || pop) && !bus.Flush;

    always_comb begin
        state_next  = state_reg;
        skip_next   = skip_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        sat_next    = sat_reg;
        ovf_next    = ovf_reg;
        if (bus.Flush) begin
            state_next  = START_STATE;
            skip_next   = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            sat_next    = 1'b0;
            ovf_next    = 1'b0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (bus.In_Valid) begin
                        skip_next = skip_reg + SW'(1);
                        if (skip_reg == SKIP_LAST) begin
                            state_next = RUN;
                        end
                    end
                end
                RUN: begin
                    // Clipped samples flag saturation even when they are dropped.
                    if (bus.In_Valid && clip) begin
                        sat_next = 1'b1;
                    end
                    if (bus.In_Valid && full && !pop) begin
                        ovf_next = 1'b1;
                    end
                end
                default: state_next = START_STATE;
            endcase
            if (push) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg  <= START_STATE;
            skip_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            sat_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            skip_reg   <= skip_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            sat_reg    <= sat_next;
            ovf_reg    <= ovf_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= sat_data;
        end
    end

    // Storage is never reset, so the head is masked to zero while empty.
    assign bus.Out_Valid = (count_reg != '0);
    assign bus.Out_Data  = bus.Out_Valid ? mem[rd_ptr_reg] : '0;
    assign bus.Count     = count_reg;
    assign bus.Sat_Flag  = sat_reg;
    assign bus.Overflow  = ovf_reg;
endmodule
